// File: rtl/sdma_inst_encoder_if.sv
// Host-side bus of the SDMA instruction encoder: staging writes, commit,
// error clear and the valid/ready instruction output toward the decoder.
interface sdma_inst_encoder_if #(
  parameter int INST_WIDTH = 512,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int NWORDS = INST_WIDTH / WORD_WIDTH;
  // One extra index bit so out-of-range word indexes can be presented and flagged.
  localparam int IDXW   = $clog2(NWORDS) + 1;
  localparam int LVLW   = $clog2(FIFO_DEPTH) + 1;

  logic                  i_sie_wr_en;
  logic [IDXW-1:0]       i_sie_wr_idx;
  logic [WORD_WIDTH-1:0] i_sie_wr_data;
  logic                  i_sie_commit;
  logic                  i_sie_err_clr;
  logic [INST_WIDTH-1:0] o_sie_inst;
  logic                  o_sie_inst_valid;
  logic                  i_sie_inst_ready;
  logic [LVLW-1:0]       o_sie_level;
  logic                  o_sie_full;
  logic [2:0]            o_sie_err;

  modport master (
    output i_sie_wr_en, i_sie_wr_idx, i_sie_wr_data, i_sie_commit, i_sie_err_clr,
    output i_sie_inst_ready,
    input  o_sie_inst, o_sie_inst_valid, o_sie_level, o_sie_full, o_sie_err
  );

  modport slave (
    input  i_sie_wr_en, i_sie_wr_idx, i_sie_wr_data, i_sie_commit, i_sie_err_clr,
    input  i_sie_inst_ready,
    output o_sie_inst, o_sie_inst_valid, o_sie_level, o_sie_full, o_sie_err
  );
endinterface

// File: rtl/sdma_inst_encoder.sv
// SDMA instruction encoder: stages an instruction word-by-word from the host,
// commits complete instructions into a small FIFO and presents the head to
// the instruction decoder over valid/ready. Sticky error flags record bad
// indexes, incomplete commits and commits that found the FIFO full.
module sdma_inst_encoder #(
  parameter int INST_WIDTH = 512,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               i_sie_clk,
  input  logic               i_sie_rst,
  sdma_inst_encoder_if.slave bus
);
  localparam int NWORDS = INST_WIDTH / WORD_WIDTH;
  localparam int IDXW   = $clog2(NWORDS) + 1;
  localparam int LVLW   = $clog2(FIFO_DEPTH) + 1;
  localparam int PTRW   = $clog2(FIFO_DEPTH);

  logic [INST_WIDTH-1:0] staging_q, staging_d;
  logic [NWORDS-1:0]     mask_q, mask_d, mask_m;
  logic [INST_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]       wptr_q, rptr_q;
  logic [LVLW-1:0]       level_q, level_d;
  logic [2:0]            err_q, err_d;
  logic                  idx_ok, complete, room, push, pop;

  // Merge the same-cycle write into staging/mask, decide push/pop, update errors.
  always_comb begin
    staging_d = staging_q;
    mask_m    = mask_q;
    idx_ok    = bus.i_sie_wr_idx < IDXW'(NWORDS);
    for (int k = 0; k < NWORDS; k++) begin
      if (bus.i_sie_wr_en && idx_ok && bus.i_sie_wr_idx == IDXW'(k)) begin
        staging_d[k*WORD_WIDTH +: WORD_WIDTH] = bus.i_sie_wr_data;
        mask_m[k] = 1'b1;
      end
    end
    complete = &mask_m;
    pop      = (level_q != '0) && bus.i_sie_inst_ready;
    room     = (level_q != LVLW'(FIFO_DEPTH)) || pop;
    push     = bus.i_sie_commit && complete && room;
    mask_d   = push ? '0 : mask_m;

    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVLW'(1);
    else if (!push && pop) level_d = level_q - LVLW'(1);

    // Clear first so an error event in the clearing cycle still lands.
    err_d = bus.i_sie_err_clr ? 3'b000 : err_q;
    if (bus.i_sie_wr_en && !idx_ok)               err_d[0] = 1'b1;
    if (bus.i_sie_commit && !complete)            err_d[1] = 1'b1;
    if (bus.i_sie_commit && complete && !room)    err_d[2] = 1'b1;
  end

  // Staging register, written-word mask and sticky error flags.
  always_ff @(posedge i_sie_clk or posedge i_sie_rst) begin
    if (i_sie_rst) begin
      staging_q <= '0;
      mask_q    <= '0;
      err_q     <= '0;
    end else begin
      staging_q <= staging_d;
      mask_q    <= mask_d;
      err_q     <= err_d;
    end
  end

  // Instruction FIFO storage, pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge i_sie_clk or posedge i_sie_rst) begin
    if (i_sie_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= staging_d;
        wptr_q        <= wptr_q + PTRW'(1);
      end
      if (pop) rptr_q <= rptr_q + PTRW'(1);
      level_q <= level_d;
    end
  end

  assign bus.o_sie_inst       = mem_q[rptr_q];
  assign bus.o_sie_inst_valid = (level_q != '0);
  assign bus.o_sie_level      = level_q;
  assign bus.o_sie_full       = (level_q == LVLW'(FIFO_DEPTH));
  assign bus.o_sie_err        = err_q;
endmodule

// File: tb/tb_sdma_inst_encoder.sv
// Directed bench for sdma_inst_encoder: inputs change on the falling edge,
// outputs are checked on the falling edge after each rising edge.
module tb_sdma_inst_encoder;
  localparam int IW = 512;
  localparam int WW = 32;
  localparam int D  = 4;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdma_inst_encoder_if #(.INST_WIDTH(IW), .WORD_WIDTH(WW), .FIFO_DEPTH(D)) sie_if ();

  sdma_inst_encoder #(.INST_WIDTH(IW), .WORD_WIDTH(WW), .FIFO_DEPTH(D)) dut (
    .i_sie_clk (clk),
    .i_sie_rst (rst),
    .bus       (sie_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [31:0] base);
    logic [IW-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) r[k*WW +: WW] = base + 32'(k);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input int idx, input logic [31:0] data);
    sie_if.i_sie_wr_en   = 1'b1;
    sie_if.i_sie_wr_idx  = 5'(idx);
    sie_if.i_sie_wr_data = data;
    step();
    sie_if.i_sie_wr_en   = 1'b0;
  endtask

  task automatic write_words(input logic [31:0] base, input int last);
    for (int k = 0; k <= last; k++) write_word(k, base + 32'(k));
  endtask

  task automatic do_commit();
    sie_if.i_sie_commit = 1'b1;
    step();
    sie_if.i_sie_commit = 1'b0;
  endtask

  task automatic err_clear();
    sie_if.i_sie_err_clr = 1'b1;
    step();
    sie_if.i_sie_err_clr = 1'b0;
  endtask

  initial begin
    sie_if.i_sie_wr_en      = 1'b0;
    sie_if.i_sie_wr_idx     = '0;
    sie_if.i_sie_wr_data    = '0;
    sie_if.i_sie_commit     = 1'b0;
    sie_if.i_sie_err_clr    = 1'b0;
    sie_if.i_sie_inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", IW'(sie_if.o_sie_inst_valid), IW'(0));
    chk("rst_level", IW'(sie_if.o_sie_level), IW'(0));
    chk("rst_full",  IW'(sie_if.o_sie_full), IW'(0));
    chk("rst_err",   IW'(sie_if.o_sie_err), IW'(0));
    chk("rst_inst",  sie_if.o_sie_inst, '0);
    rst = 1'b0;
    @(negedge clk);

    // 1: full write, commit, one-cycle latency, pop
    write_words(32'h1000, 15);
    sie_if.i_sie_inst_ready = 1'b1;
    chk("t1_pre_valid", IW'(sie_if.o_sie_inst_valid), IW'(0));
    do_commit();
    chk("t1_valid", IW'(sie_if.o_sie_inst_valid), IW'(1));
    chk("t1_inst",  sie_if.o_sie_inst, mk(32'h1000));
    chk("t1_level1", IW'(sie_if.o_sie_level), IW'(1));
    step();
    chk("t1_level0", IW'(sie_if.o_sie_level), IW'(0));
    chk("t1_valid0", IW'(sie_if.o_sie_inst_valid), IW'(0));
    sie_if.i_sie_inst_ready = 1'b0;

    // 2: incomplete commit then completion
    write_words(32'h2000, 14);
    do_commit();
    chk("t2_novalid", IW'(sie_if.o_sie_inst_valid), IW'(0));
    chk("t2_err",     IW'(sie_if.o_sie_err), IW'(3'b010));
    write_word(15, 32'h200F);
    do_commit();
    chk("t2_level", IW'(sie_if.o_sie_level), IW'(1));
    chk("t2_inst",  sie_if.o_sie_inst, mk(32'h2000));
    chk("t2_err_kept", IW'(sie_if.o_sie_err), IW'(3'b010));
    err_clear();
    chk("t2_err_clr", IW'(sie_if.o_sie_err), IW'(0));
    sie_if.i_sie_inst_ready = 1'b1;
    step();
    sie_if.i_sie_inst_ready = 1'b0;
    chk("t2_drained", IW'(sie_if.o_sie_level), IW'(0));

    // 3: fill to full, overflow commit, drain in order
    for (int i = 0; i < 5; i++) begin
      write_words(32'h3000_0000 + (32'(i) << 8), 15);
      do_commit();
    end
    chk("t3_level", IW'(sie_if.o_sie_level), IW'(4));
    chk("t3_full",  IW'(sie_if.o_sie_full), IW'(1));
    chk("t3_err",   IW'(sie_if.o_sie_err), IW'(3'b100));
    sie_if.i_sie_inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_order%0d", i), sie_if.o_sie_inst, mk(32'h3000_0000 + (32'(i) << 8)));
      step();
    end
    chk("t3_empty", IW'(sie_if.o_sie_level), IW'(0));
    sie_if.i_sie_inst_ready = 1'b0;
    err_clear();

    // 4: commit into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 4; i++) begin
      write_words(32'h4000_0000 + (32'(i) << 8), 15);
      do_commit();
    end
    chk("t4_full", IW'(sie_if.o_sie_full), IW'(1));
    write_words(32'h4000_0400, 15);
    sie_if.i_sie_inst_ready = 1'b1;
    do_commit();
    chk("t4_level", IW'(sie_if.o_sie_level), IW'(4));
    chk("t4_err",   IW'(sie_if.o_sie_err), IW'(0));
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t4_order%0d", i), sie_if.o_sie_inst, mk(32'h4000_0000 + (32'(i) << 8)));
      step();
    end
    chk("t4_empty", IW'(sie_if.o_sie_level), IW'(0));
    sie_if.i_sie_inst_ready = 1'b0;

    // 5: bad index, err_clr vs new event, write merged into commit
    write_words(32'h5000, 14);
    write_word(16, 32'hDEAD_BEEF);
    chk("t5_err_idx", IW'(sie_if.o_sie_err), IW'(3'b001));
    sie_if.i_sie_err_clr = 1'b1;
    write_word(16, 32'hBAD0_0000);
    sie_if.i_sie_err_clr = 1'b0;
    chk("t5_clr_vs_event", IW'(sie_if.o_sie_err), IW'(3'b001));
    sie_if.i_sie_wr_en   = 1'b1;
    sie_if.i_sie_wr_idx  = 5'd15;
    sie_if.i_sie_wr_data = 32'h500F;
    do_commit();
    sie_if.i_sie_wr_en   = 1'b0;
    chk("t5_merge_level", IW'(sie_if.o_sie_level), IW'(1));
    chk("t5_merge_inst",  sie_if.o_sie_inst, mk(32'h5000));
    chk("t5_err_after",   IW'(sie_if.o_sie_err), IW'(3'b001));
    sie_if.i_sie_inst_ready = 1'b1;
    step();
    sie_if.i_sie_inst_ready = 1'b0;

    // 6: asynchronous reset mid-drain, then fresh traffic
    for (int i = 0; i < 4; i++) begin
      write_words(32'h6000_0000 + (32'(i) << 8), 15);
      do_commit();
    end
    sie_if.i_sie_inst_ready = 1'b1;
    step();
    chk("t6_level3", IW'(sie_if.o_sie_level), IW'(3));
    chk("t6_err_pre", IW'(sie_if.o_sie_err), IW'(3'b001));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", IW'(sie_if.o_sie_inst_valid), IW'(0));
    chk("t6_rst_level", IW'(sie_if.o_sie_level), IW'(0));
    chk("t6_rst_err",   IW'(sie_if.o_sie_err), IW'(0));
    @(negedge clk);
    rst = 1'b0;
    sie_if.i_sie_inst_ready = 1'b0;
    write_words(32'h7000, 15);
    do_commit();
    chk("t6_fresh_valid", IW'(sie_if.o_sie_inst_valid), IW'(1));
    chk("t6_fresh_inst",  sie_if.o_sie_inst, mk(32'h7000));
    chk("t6_fresh_level", IW'(sie_if.o_sie_level), IW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
